// File: rtl/mac_datapath_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_datapath_if
// Description : Bus bundle between the MAC controller/host and mac_datapath.
//               Carries the operand write port, the job configuration, the
//               per-cycle control strobes and the published result.
//               master : controller/host side (drives strobes, reads result)
//               slave  : datapath side
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_datapath_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) ();

    localparam int ACC_W = 2 * WIDTH + ADDR_W;

    // Operand write port
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WIDTH-1:0]    wr_data_a;
    logic [WIDTH-1:0]    wr_data_b;

    // Job configuration and control strobes
    logic [ADDR_W:0]     cfg_len;
    logic                start;
    logic                load_a;
    logic                load_b;
    logic                count_enable;
    logic                load_m;
    logic                load_acc;
    logic                load_out;

    // Status and result
    logic                cmp;
    logic [ACC_W-1:0]    result;
    logic                result_valid;
    logic [ADDR_W:0]     count;

    modport master (
        output wr_en, wr_addr, wr_data_a, wr_data_b,
        output cfg_len, start, load_a, load_b, count_enable,
        output load_m, load_acc, load_out,
        input  cmp, result, result_valid, count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data_a, wr_data_b,
        input  cfg_len, start, load_a, load_b, count_enable,
        input  load_m, load_acc, load_out,
        output cmp, result, result_valid, count
    );

endinterface
`default_nettype wire

// File: rtl/mac_datapath.sv
`default_nettype none
// ============================================================================
// Module      : mac_datapath
// Description : Arithmetic/storage half of the multiply-accumulate unit.
//               Holds operand vectors A and B, fetches one element pair per
//               term under controller strobes, multiplies, accumulates and
//               publishes the dot product.
// Ports       : clk  - clock, all state on rising edge
//               rst  - synchronous active-high reset
//               bus  - mac_datapath_if.slave (write port, cfg_len, start,
//                      load_a/load_b/count_enable/load_m/load_acc/load_out,
//                      cmp, result, result_valid, count)
// Revision    : 1.0 - initial release
// ============================================================================
module mac_datapath #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    mac_datapath_if.slave   bus
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int IDX_W  = ADDR_W + 1;
    localparam int PROD_W = 2 * WIDTH;
    localparam int ACC_W  = 2 * WIDTH + ADDR_W;

    localparam logic [IDX_W-1:0] C_DEPTH = IDX_W'(DEPTH);
    localparam logic [IDX_W-1:0] C_ONE   = IDX_W'(1);

    // Operand storage (no reset)
    logic [WIDTH-1:0]  r_mem_a [DEPTH];
    logic [WIDTH-1:0]  r_mem_b [DEPTH];

    logic [IDX_W-1:0]  r_idx;
    logic [WIDTH-1:0]  r_a_reg;
    logic [WIDTH-1:0]  r_b_reg;
    logic [PROD_W-1:0] r_m_reg;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_result;
    logic              r_result_valid;

    logic [IDX_W-1:0]  w_len_eff;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_rd_addr = r_idx[ADDR_W-1:0];

    // Both arrays share one write address. Reads elsewhere sample the array
    // through non-blocking updates, so a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            r_mem_a[bus.wr_addr] <= bus.wr_data_a;
            r_mem_b[bus.wr_addr] <= bus.wr_data_b;
        end
    end

    // Clamp the requested length into 1..DEPTH. cfg_len is quasi-static
    // configuration held for the whole job.
    always_comb begin
        w_len_eff = bus.cfg_len;
        if (bus.cfg_len == '0) begin
            w_len_eff = C_ONE;
        end else if (bus.cfg_len > C_DEPTH) begin
            w_len_eff = C_DEPTH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx          <= '0;
            r_a_reg        <= '0;
            r_b_reg        <= '0;
            r_m_reg        <= '0;
            r_acc          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else if (bus.start) begin
            // A new job drops any partial sum; operands and the last
            // published result are left untouched.
            r_idx          <= '0;
            r_m_reg        <= '0;
            r_acc          <= '0;
            r_result_valid <= 1'b0;
        end else begin
            if (bus.load_a) begin
                r_a_reg <= r_mem_a[w_rd_addr];
            end
            if (bus.load_b) begin
                r_b_reg <= r_mem_b[w_rd_addr];
            end
            // Saturate at DEPTH so cmp cannot fall back low on overrun.
            if (bus.count_enable && (r_idx < C_DEPTH)) begin
                r_idx <= r_idx + C_ONE;
            end
            if (bus.load_m) begin
                r_m_reg <= PROD_W'(r_a_reg) * PROD_W'(r_b_reg);
            end
            if (bus.load_acc) begin
                r_acc <= r_acc + ACC_W'(r_m_reg);
            end
            if (bus.load_out) begin
                r_result <= r_acc;
            end
            r_result_valid <= bus.load_out;
        end
    end

    assign bus.cmp          = (r_idx >= w_len_eff);
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign bus.count        = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_mac_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_datapath
// Description : Directed self-checking bench for mac_datapath. Drives the
//               controller strobe sequence by hand and compares outputs with
//               hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mac_datapath;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mac_datapath_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    mac_datapath #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_strobes();
        bus.start        = 1'b0;
        bus.load_a       = 1'b0;
        bus.load_b       = 1'b0;
        bus.count_enable = 1'b0;
        bus.load_m       = 1'b0;
        bus.load_acc     = 1'b0;
        bus.load_out     = 1'b0;
        bus.wr_en        = 1'b0;
    endtask

    task automatic write_pair(input int addr, input int a, input int b);
        bus.wr_en     = 1'b1;
        bus.wr_addr   = ADDR_W'(addr);
        bus.wr_data_a = WIDTH'(a);
        bus.wr_data_b = WIDTH'(b);
        tick();
        bus.wr_en     = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // One term: fetch+advance, idle, multiply, idle, accumulate, cmp sample.
    task automatic term();
        bus.load_a = 1'b1; bus.load_b = 1'b1; bus.count_enable = 1'b1;
        tick();
        clear_strobes();
        tick();
        bus.load_m = 1'b1;
        tick();
        clear_strobes();
        tick();
        bus.load_acc = 1'b1;
        tick();
        clear_strobes();
        tick();
    endtask

    task automatic publish();
        bus.load_out = 1'b1;
        tick();
        bus.load_out = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        clear_strobes();
        bus.wr_addr   = '0;
        bus.wr_data_a = '0;
        bus.wr_data_b = '0;
        bus.cfg_len   = 5'd3;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_result", 32'(bus.result), 0);
        check("rst_valid",  32'(bus.result_valid), 0);
        check("rst_count",  32'(bus.count), 0);
        check("rst_cmp",    32'(bus.cmp), 0);
        rst = 1'b0;
        tick();

        // ---------------- basic dot product ----------------
        write_pair(0, 1, 4);
        write_pair(1, 2, 5);
        write_pair(2, 3, 6);
        bus.cfg_len = 5'd3;
        do_start();
        check("basic_count0", 32'(bus.count), 0);
        term();
        check("basic_cmp_t1", 32'(bus.cmp), 0);
        term();
        check("basic_cmp_t2", 32'(bus.cmp), 0);
        term();
        check("basic_cmp_t3", 32'(bus.cmp), 1);
        check("basic_valid_c18", 32'(bus.result_valid), 0);
        publish();
        check("basic_valid_c19", 32'(bus.result_valid), 1);
        check("basic_result", 32'(bus.result), 32);
        tick();
        check("basic_valid_pulse", 32'(bus.result_valid), 0);
        check("basic_result_hold", 32'(bus.result), 32);

        // ---------------- reset mid-job ----------------
        do_start();
        term();
        term();
        check("midrst_count2", 32'(bus.count), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_result", 32'(bus.result), 0);
        check("midrst_valid",  32'(bus.result_valid), 0);
        check("midrst_count",  32'(bus.count), 0);
        check("midrst_cmp",    32'(bus.cmp), 0);
        publish();
        check("midrst_acc_zero", 32'(bus.result), 0);
        check("midrst_valid1",   32'(bus.result_valid), 1);

        // ---------------- start colliding with load_acc ----------------
        publish();  // result := acc (still 0) so the hold below is meaningful
        do_start();
        term();
        term();          // acc = 4 + 10 = 14
        bus.load_a = 1'b1; bus.load_b = 1'b1; bus.count_enable = 1'b1;
        tick();
        clear_strobes();
        tick();
        bus.load_m = 1'b1;
        tick();
        clear_strobes();
        tick();
        bus.start = 1'b1; bus.load_acc = 1'b1;
        tick();
        clear_strobes();
        check("abort_count", 32'(bus.count), 0);
        check("abort_cmp",   32'(bus.cmp), 0);
        check("abort_valid", 32'(bus.result_valid), 0);
        // New job with cfg_len=0 -> exactly one term A[0]*B[0]
        bus.cfg_len = 5'd0;
        term();
        check("len0_cmp", 32'(bus.cmp), 1);
        check("len0_count", 32'(bus.count), 1);
        publish();
        check("len0_result", 32'(bus.result), 4);

        // ---------------- write/read collision at idx 0 ----------------
        bus.cfg_len = 5'd1;
        do_start();
        bus.wr_en = 1'b1; bus.wr_addr = '0;
        bus.wr_data_a = 8'd9; bus.wr_data_b = 8'd4;
        bus.load_a = 1'b1; bus.load_b = 1'b1; bus.count_enable = 1'b1;
        tick();
        clear_strobes();
        tick();
        bus.load_m = 1'b1;
        tick();
        clear_strobes();
        tick();
        bus.load_acc = 1'b1;
        tick();
        clear_strobes();
        tick();
        publish();
        check("coll_old_data", 32'(bus.result), 4);
        do_start();
        term();
        publish();
        check("coll_new_data", 32'(bus.result), 36);

        // ---------------- full scale, cfg_len = 16 ----------------
        for (int i = 0; i < 16; i++) begin
            write_pair(i, 255, 255);
        end
        bus.cfg_len = 5'd16;
        do_start();
        for (int t = 0; t < 15; t++) begin
            term();
        end
        check("full_cmp_t15", 32'(bus.cmp), 0);
        term();
        check("full_cmp_t16", 32'(bus.cmp), 1);
        publish();
        check("full_result", 32'(bus.result), 32'h000FE010);
        bus.count_enable = 1'b1;
        tick();
        tick();
        bus.count_enable = 1'b0;
        check("full_count_sat", 32'(bus.count), 16);
        check("full_cmp_hold",  32'(bus.cmp), 1);

        // ---------------- cfg_len = 31 clamps to 16 ----------------
        bus.cfg_len = 5'd31;
        do_start();
        for (int t = 0; t < 15; t++) begin
            term();
        end
        check("len31_cmp_t15", 32'(bus.cmp), 0);
        term();
        check("len31_cmp_t16", 32'(bus.cmp), 1);
        publish();
        check("len31_result", 32'(bus.result), 32'd1040400);

        // ---------------- back-to-back load_m / load_acc ----------------
        write_pair(0, 7, 11);
        bus.cfg_len = 5'd1;
        do_start();
        bus.load_a = 1'b1; bus.load_b = 1'b1; bus.count_enable = 1'b1;
        tick();
        clear_strobes();
        bus.load_m = 1'b1;
        tick();
        clear_strobes();
        bus.load_acc = 1'b1;
        tick();
        clear_strobes();
        publish();
        check("b2b_result", 32'(bus.result), 77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
